// File: rtl/shift_frame_sequencer.sv
// Purpose : serializes one WIDTH-bit word per frame as start(0), data LSB first,
//           optional even parity, stop(1). Each serial bit is held DIV clk cycles.
// Latency : start bit on sout the cycle after accept. A frame lasts (2+WIDTH+P)*DIV cycles.
// Backpressure: in_ready is high only in IDLE. in_valid/in_data are ignored while busy.
//
// Build option: define SHIFT_FRAME_PARITY_EN to insert an even-parity bit
//               (XOR of the loaded word) between the last data bit and stop.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - asynchronous active-high reset
//   in_data   - parallel word to serialize (WIDTH bits)
//   in_valid  - in_data is valid
//   in_ready  - block can accept a word this cycle (registered, high in IDLE)
//   abort     - synchronous frame cancel; in IDLE it only blocks acceptance
//   sout      - serial output line, idles high (registered)
//   busy      - high in every non-IDLE state (registered)
//   done      - one-cycle pulse on the first IDLE cycle after a normal frame end
`timescale 1ns/1ps

module shift_frame_sequencer #(
  parameter int WIDTH = 4,  // data bits per frame, 2..16
  parameter int DIV   = 1   // clk cycles per serial bit, 1..255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef SHIFT_FRAME_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  // Counter terminal values, sized to the counter registers.
  localparam logic [7:0] PRESC_LAST = 8'(DIV - 1);
  localparam logic [3:0] BIT_LAST   = 4'(WIDTH - 1);

  logic [2:0]       state;
  logic [7:0]       presc;
  logic [3:0]       bitcnt;
  logic [WIDTH-1:0] shift_reg;
`ifdef SHIFT_FRAME_PARITY_EN
  logic             parity;
`endif

  // The prescaler wrapping marks the last cycle of the current serial bit;
  // every state/bit transition happens only on that cycle.
  logic presc_wrap;
  assign presc_wrap = (presc == PRESC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      presc     <= '0;
      bitcnt    <= '0;
      shift_reg <= '0;
`ifdef SHIFT_FRAME_PARITY_EN
      parity    <= 1'b0;
`endif
      sout      <= 1'b1;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (state != S_IDLE && abort) begin
      // Cancel: back to idle with everything cleared and no done pulse.
      state     <= S_IDLE;
      presc     <= '0;
      bitcnt    <= '0;
      shift_reg <= '0;
`ifdef SHIFT_FRAME_PARITY_EN
      parity    <= 1'b0;
`endif
      sout      <= 1'b1;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // done only survives the first idle cycle after a frame.
          done <= 1'b0;
          // in_ready is high throughout IDLE, so accept needs only valid and no abort.
          if (in_valid && !abort) begin
            state     <= S_START;
            shift_reg <= in_data;
`ifdef SHIFT_FRAME_PARITY_EN
            parity    <= ^in_data;
`endif
            presc     <= '0;
            bitcnt    <= '0;
            sout      <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end

        S_START: begin
          presc <= presc_wrap ? 8'd0 : presc + 8'd1;
          if (presc_wrap) begin
            // sout is registered, so present bit 0 now and shift it out of the
            // register; bit k is then always in shift_reg[0] when it is needed.
            state     <= S_DATA;
            sout      <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bitcnt    <= '0;
          end
        end

        S_DATA: begin
          presc <= presc_wrap ? 8'd0 : presc + 8'd1;
          if (presc_wrap) begin
            if (bitcnt == BIT_LAST) begin
`ifdef SHIFT_FRAME_PARITY_EN
              state <= S_PARITY;
              sout  <= parity;
`else
              state <= S_STOP;
              sout  <= 1'b1;
`endif
              bitcnt <= '0;
            end else begin
              bitcnt    <= bitcnt + 4'd1;
              sout      <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
        end

`ifdef SHIFT_FRAME_PARITY_EN
        S_PARITY: begin
          presc <= presc_wrap ? 8'd0 : presc + 8'd1;
          if (presc_wrap) begin
            state <= S_STOP;
            sout  <= 1'b1;
          end
        end
`endif

        S_STOP: begin
          presc <= presc_wrap ? 8'd0 : presc + 8'd1;
          if (presc_wrap) begin
            state    <= S_IDLE;
            sout     <= 1'b1;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end

        default: begin
          // Unreachable encodings recover to a clean idle.
          state     <= S_IDLE;
          presc     <= '0;
          bitcnt    <= '0;
          shift_reg <= '0;
          sout      <= 1'b1;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_frame_sequencer.sv
`timescale 1ns/1ps

module tb_shift_frame_sequencer;

  localparam int W = 4;
  localparam int D = 3;
`ifdef SHIFT_FRAME_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FLEN = (2 + W + P) * D;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         abort;
  logic         in_ready;
  logic         sout;
  logic         busy;
  logic         done;

  shift_frame_sequencer #(.WIDTH(W), .DIV(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .abort    (abort),
    .sout     (sout),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Expected outputs for one clock cycle, tagged with that cycle's index.
  typedef struct {
    int   cyc;
    logic sout;
    logic busy;
    logic rdy;
    logic done;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle, compare against the scheduled expectation for that
  // cycle, or against the idle line when nothing is scheduled.
  exp_t e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].cyc == cyc) e = q.pop_front();
      else e = '{cyc, 1'b1, 1'b0, 1'b1, 1'b0};
      chk("sout",     sout,     e.sout);
      chk("busy",     busy,     e.busy);
      chk("in_ready", in_ready, e.rdy);
      chk("done",     done,     e.done);
    end
  end

  // Reference: model is busy in the current cycle if a busy entry is scheduled for it.
  function automatic bit model_busy();
    return (q.size() > 0) && (q[0].cyc == cyc) && q[0].busy;
  endfunction

  // Schedule a whole frame: line levels per serial bit, each lasting D cycles,
  // followed by one done cycle.
  task automatic push_frame(input logic [W-1:0] d, input int first);
    logic bits[$];
    int   c;
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(d[i]);
    if (P == 1) bits.push_back(^d);
    bits.push_back(1'b1);
    c = first;
    foreach (bits[k]) begin
      for (int r = 0; r < D; r++) begin
        q.push_back('{c, bits[k], 1'b1, 1'b0, 1'b0});
        c++;
      end
    end
    q.push_back('{c, 1'b1, 1'b0, 1'b1, 1'b1});
  endtask

  // Drive inputs for the coming edge, update the reference, advance one cycle.
  task automatic step(input logic v, input logic [W-1:0] d, input logic a, output bit accepted);
    in_valid = v;
    in_data  = d;
    abort    = a;
    accepted = 1'b0;
    if (model_busy()) begin
      if (a) begin
        while (q.size() > 0 && q[q.size()-1].cyc > cyc) q.delete(q.size()-1);
      end
    end else if (v && !a) begin
      push_frame(d, cyc + 1);
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), 1'b0, acc);
  endtask

  initial begin
    bit           acc;
    logic [W-1:0] word;
    int           guard;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    abort    = 1'b0;
    #2;
    chk("rst_sout",     sout,     1'b1);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy",     busy,     1'b0);
    chk("rst_done",     done,     1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Single frame, each bit held D cycles.
    step(1'b1, 4'b0001, 1'b0, acc);
    idle(FLEN + 2);
    step(1'b1, 4'b1011, 1'b0, acc);
    idle(FLEN + 2);

    // in_valid held high: 4'hA then 4'h5 back-to-back.
    word  = 4'hA;
    guard = 0;
    while (guard < 4 * FLEN) begin
      step(1'b1, word, 1'b0, acc);
      guard++;
      if (acc && word == 4'h5) break;
      if (acc) word = 4'h5;
    end
    idle(FLEN + 2);

    // Abort during the third data bit.
    step(1'b1, 4'b0110, 1'b0, acc);
    idle(3 * D);
    step(1'b0, 4'b0000, 1'b1, acc);
    idle(3);

    // Abort while idle blocks acceptance.
    step(1'b1, 4'b1111, 1'b1, acc);
    idle(2);

    // Asynchronous reset in the middle of the data bits.
    step(1'b1, 4'b1001, 1'b0, acc);
    idle(D + 2);
    mon_en = 1'b0;
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sout",     sout,     1'b1);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_busy",     busy,     1'b0);
    chk("arst_done",     done,     1'b0);
    q.delete();
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    idle(2);
    step(1'b1, 4'b0101, 1'b0, acc);
    idle(FLEN + 2);

    // Randomized traffic with occasional aborts.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 39) == 0), acc);
    end
    idle(FLEN + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
